// File: rtl/fu_seqadd32v_if.sv
// fu_seqadd32v_if: request/response bundle for the nibble-serial adder.
//   start      requester -> unit   launch an operation (taken in IDLE/DONE)
//   sub        requester -> unit   0: din1+din2, 1: din1-din2
//   sat        requester -> unit   clamp on signed overflow (saturating builds only)
//   din1/din2  requester -> unit   WIDTH-bit operands
//   busy       unit -> requester   operation in flight
//   done       unit -> requester   one-cycle result-valid pulse
//   dout       unit -> requester   result, held until the next accepted start
//   carry_out/overflow/zero        flags of the full-width operation
interface fu_seqadd32v_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             sub;
  logic             sat;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, sat, din1, din2,
    input  busy, done, dout, carry_out, overflow, zero
  );

  modport slave (
    input  start, sub, sat, din1, din2,
    output busy, done, dout, carry_out, overflow, zero
  );
endinterface

// File: rtl/fu_seqadd32v.sv
// fu_seqadd32v: multi-cycle WIDTH-bit add/subtract. One 4-bit carry-lookahead
// slice is swept across the operands, one nibble per clock, with the inter-
// nibble carry kept in a register. Start-to-done latency is WIDTH/4 cycles.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active high (aborts any operation in flight)
//   bus   fu_seqadd32v_if.slave: start/sub/sat/din1/din2 in,
//         busy/done/dout/carry_out/overflow/zero out
//
// Build option: define FU_SEQADD_SAT_EN to enable signed saturation. When
// enabled and sat was high at start, an overflowing result is clamped to the
// largest positive / most negative value at the final nibble step. Without
// the macro, sat is ignored and the result always wraps.
module fu_seqadd32v #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  fu_seqadd32v_if.slave bus
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;     // already inverted for subtract
  logic             cy_q, cy_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
`ifdef FU_SEQADD_SAT_EN
  logic             sat_q, sat_d;
`endif

  // Nibble slice operands and lookahead terms
  logic [3:0] na, nb, g, p, sum;
  logic [4:0] c;

  always_comb begin
    na = a_q[{idx_q, 2'b00} +: 4];
    nb = b_q[{idx_q, 2'b00} +: 4];
    g  = na & nb;
    p  = na ^ nb;
    c[0] = cy_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum = p ^ c[3:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cy_d    = cy_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
`ifdef FU_SEQADD_SAT_EN
    sat_d   = sat_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          // Subtract is A + ~B + 1: invert B here, seed the carry with sub.
          a_d     = bus.din1;
          b_d     = bus.din2 ^ {WIDTH{bus.sub}};
          cy_d    = bus.sub;
          idx_d   = '0;
`ifdef FU_SEQADD_SAT_EN
          sat_d   = bus.sat;
`endif
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        dout_d[{idx_q, 2'b00} +: 4] = sum;
        cy_d  = c[4];
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // Top slice: c[3] is the carry into the MSB, c[4] the carry out.
          idx_d  = '0;
          cout_d = c[4];
          ovf_d  = c[3] ^ c[4];
`ifdef FU_SEQADD_SAT_EN
          // Operand A's sign gives the overflow direction.
          if (sat_q && (c[3] ^ c[4]))
            dout_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
`endif
          zero_d  = (dout_d == '0);
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      idx_q   <= '0;
      dout_q  <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
`ifdef FU_SEQADD_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`ifdef FU_SEQADD_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.dout      = dout_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_fu_seqadd32v.sv
module tb_fu_seqadd32v;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fu_seqadd32v_if #(.WIDTH(32)) bus ();
  fu_seqadd32v #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Launches one operation and waits (bounded) for done.
  // Returns cycles from the accepting edge to done (99 on timeout)
  // and whether busy was high on every cycle before done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic st,
                        output int lat, output bit busy_ok);
    bus.din1 = a; bus.din2 = b; bus.sub = s; bus.sat = st; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 99; busy_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (!bus.done && !bus.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      if (bus.done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.dout, bus.carry_out, bus.overflow, bus.zero}
        !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b dout=%h cout=%b ovf=%b zero=%b, want 0 0 00000000 0 0 1",
               bus.busy, bus.done, bus.dout, bus.carry_out, bus.overflow, bus.zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Shared checking body is written out per test to keep comparisons inline.
  task automatic test_add();
    int lat; bit bok;
    run_op(32'h1, 32'h1, 1'b0, 1'b0, lat, bok);
    tests++;
    if (lat !== 8 || !bok) begin
      fails++; $display("FAIL add latency: got %0d busy_ok=%b, want 8 1", lat, bok);
    end
    tests++;
    if ({bus.dout, bus.carry_out, bus.overflow, bus.zero, bus.busy} !== {32'h2, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL add result: dout=%h c=%b v=%b z=%b busy=%b, want 00000002 0 0 0 0",
                        bus.dout, bus.carry_out, bus.overflow, bus.zero, bus.busy);
    end
    // Done lasts one cycle, then IDLE with result held.
    @(posedge clk); #1;
    tests++;
    if ({bus.done, bus.busy, bus.dout} !== {1'b0, 1'b0, 32'h2}) begin
      fails++; $display("FAIL add hold: done=%b busy=%b dout=%h, want 0 0 00000002",
                        bus.done, bus.busy, bus.dout);
    end
  endtask

  task automatic test_carry_chain();
    int lat; bit bok;
    run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, lat, bok);
    tests++;
    if (lat !== 8 || {bus.dout, bus.carry_out, bus.overflow, bus.zero} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
      fails++; $display("FAIL carry_chain: lat=%0d dout=%h c=%b v=%b z=%b, want 8 00000000 1 0 1",
                        lat, bus.dout, bus.carry_out, bus.overflow, bus.zero);
    end
  endtask

  task automatic test_sub_overflow();
    int lat; bit bok;
    logic [31:0] exp_sat;
`ifdef FU_SEQADD_SAT_EN
    exp_sat = 32'h8000_0000;
`else
    exp_sat = 32'h7FFF_FFFF;
`endif
    run_op(32'h8000_0000, 32'h1, 1'b1, 1'b0, lat, bok);
    tests++;
    if (lat !== 8 || {bus.dout, bus.carry_out, bus.overflow, bus.zero} !== {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL sub_ovf: lat=%0d dout=%h c=%b v=%b z=%b, want 8 7fffffff 1 1 0",
                        lat, bus.dout, bus.carry_out, bus.overflow, bus.zero);
    end
    run_op(32'h8000_0000, 32'h1, 1'b1, 1'b1, lat, bok);
    tests++;
    if ({bus.dout, bus.overflow, bus.zero} !== {exp_sat, 1'b1, 1'b0}) begin
      fails++; $display("FAIL sub_ovf_sat: dout=%h v=%b z=%b, want %h 1 0",
                        bus.dout, bus.overflow, bus.zero, exp_sat);
    end
    // Plain subtract with borrow: 3 - 5 = -2, carry_out 0 means borrow.
    run_op(32'h3, 32'h5, 1'b1, 1'b1, lat, bok);
    tests++;
    if ({bus.dout, bus.carry_out, bus.overflow} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin
      fails++; $display("FAIL sub_borrow: dout=%h c=%b v=%b, want fffffffe 0 0",
                        bus.dout, bus.carry_out, bus.overflow);
    end
  endtask

  task automatic test_add_overflow();
    int lat; bit bok;
    logic [31:0] exp_sat;
`ifdef FU_SEQADD_SAT_EN
    exp_sat = 32'h7FFF_FFFF;
`else
    exp_sat = 32'h8000_0000;
`endif
    run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat, bok);
    tests++;
    if ({bus.dout, bus.carry_out, bus.overflow, bus.zero} !== {32'h8000_0000, 1'b0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL add_ovf: dout=%h c=%b v=%b z=%b, want 80000000 0 1 0",
                        bus.dout, bus.carry_out, bus.overflow, bus.zero);
    end
    run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, lat, bok);
    tests++;
    if ({bus.dout, bus.overflow} !== {exp_sat, 1'b1}) begin
      fails++; $display("FAIL add_ovf_sat: dout=%h v=%b, want %h 1", bus.dout, bus.overflow, exp_sat);
    end
    // Mixed nibbles exercise every slice position.
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, lat, bok);
    tests++;
    if ({bus.dout, bus.carry_out, bus.overflow} !== {32'hACF1_3568, 1'b0, 1'b0}) begin
      fails++; $display("FAIL add_mixed: dout=%h c=%b v=%b, want acf13568 0 0",
                        bus.dout, bus.carry_out, bus.overflow);
    end
  endtask

  // Op1 (5+3) accepted at edge 0 with start held; operands change during RUN.
  // Start still high on the done cycle launches op2 (0x100-1). A start pulse
  // during op2's RUN must be ignored. Expect done exactly at t=8 and t=17.
  task automatic test_back_to_back();
    int ndone = 0;
    bus.din1 = 32'h5; bus.din2 = 32'h3; bus.sub = 1'b0; bus.sat = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.din1 = 32'h100; bus.din2 = 32'h1; bus.sub = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        tests++;
        if (t == 8) begin
          if (bus.dout !== 32'h8) begin
            fails++; $display("FAIL b2b op1: dout=%h, want 00000008", bus.dout);
          end
        end else if (t == 17) begin
          if ({bus.dout, bus.carry_out} !== {32'hFF, 1'b1}) begin
            fails++; $display("FAIL b2b op2: dout=%h c=%b, want 000000ff 1", bus.dout, bus.carry_out);
          end
        end else begin
          fails++; $display("FAIL b2b done timing: done at t=%0d, want t=8 or t=17", t);
        end
      end
      if (t == 9) begin
        tests++;
        if ({bus.busy, bus.done} !== 2'b10) begin
          fails++; $display("FAIL b2b no bubble: busy=%b done=%b, want 1 0", bus.busy, bus.done);
        end
        bus.start = 1'b0;
      end
      if (t == 10) begin
        bus.start = 1'b1; bus.din1 = 32'hFFFF; bus.din2 = 32'h0; bus.sub = 1'b0;
      end
      if (t == 11) bus.start = 1'b0;
    end
    tests++;
    if (ndone !== 2) begin
      fails++; $display("FAIL b2b done count: got %0d, want 2", ndone);
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone = 0;
    bus.din1 = 32'h1111_1111; bus.din2 = 32'h1111_1111; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus.busy, bus.dout[11:0]} !== {1'b1, 12'h222}) begin
      fails++; $display("FAIL mid_run partial: busy=%b dout[11:0]=%h, want 1 222", bus.busy, bus.dout[11:0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if ({bus.busy, bus.done, bus.dout, bus.zero} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
      fails++; $display("FAIL mid_run reset: busy=%b done=%b dout=%h z=%b, want 0 0 00000000 1",
                        bus.busy, bus.done, bus.dout, bus.zero);
    end
    for (int t = 0; t < 15; t++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) ndone++;
    end
    tests++;
    if (ndone !== 0) begin
      fails++; $display("FAIL mid_run aftermath: %0d cycles with busy/done, want 0", ndone);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.sub = 1'b0; bus.sat = 1'b0; bus.din1 = '0; bus.din2 = '0;
    test_reset();
    test_add();
    test_carry_chain();
    test_sub_overflow();
    test_add_overflow();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
